// File: rtl/lcd_bus_responder_pkg.sv
// Shared constants, instruction classes and decode helper for the character-LCD bus model.
package lcd_bus_responder_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int IDX_W  = 5;

  // DDRAM address map of a 2x16 panel
  localparam logic [ADDR_W-1:0] LINE1_BASE = 7'h00;
  localparam logic [ADDR_W-1:0] LINE2_BASE = 7'h40;
  localparam logic [ADDR_W-1:0] LINE1_END  = 7'h27;
  localparam logic [ADDR_W-1:0] LINE2_END  = 7'h67;
  localparam int                LINE_LEN   = 16;

  localparam logic [DATA_W-1:0] SPACE_CHAR = 8'h20;

  // Instruction opcode masks; the highest set bit selects the instruction
  localparam logic [DATA_W-1:0] SET_DDRAM_MASK  = 8'h80;
  localparam logic [DATA_W-1:0] SET_CGRAM_MASK  = 8'h40;
  localparam logic [DATA_W-1:0] FUNC_SET_MASK   = 8'h20;
  localparam logic [DATA_W-1:0] SHIFT_MASK      = 8'h10;
  localparam logic [DATA_W-1:0] DISP_CTRL_MASK  = 8'h08;
  localparam logic [DATA_W-1:0] ENTRY_MODE_MASK = 8'h04;
  localparam logic [DATA_W-1:0] HOME_MASK       = 8'h02;
  localparam logic [DATA_W-1:0] CLEAR_MASK      = 8'h01;

  // Operand bit positions
  localparam int DISP_D_BIT   = 2;
  localparam int ENTRY_ID_BIT = 1;
  localparam int ENTRY_S_BIT  = 0;

  typedef enum logic [2:0] {
    INS_NOP,
    INS_SET_DDRAM,
    INS_ACCEPT_ONLY,
    INS_DISP_CTRL,
    INS_ENTRY_MODE,
    INS_HOME,
    INS_CLEAR
  } instr_e;

  // Classify an instruction byte by its highest set bit
  function automatic instr_e decode_instr(input logic [DATA_W-1:0] d);
    if (|(d & SET_DDRAM_MASK))       return INS_SET_DDRAM;
    else if (|(d & SET_CGRAM_MASK))  return INS_ACCEPT_ONLY;
    else if (|(d & FUNC_SET_MASK))   return INS_ACCEPT_ONLY;
    else if (|(d & SHIFT_MASK))      return INS_ACCEPT_ONLY;
    else if (|(d & DISP_CTRL_MASK))  return INS_DISP_CTRL;
    else if (|(d & ENTRY_MODE_MASK)) return INS_ENTRY_MODE;
    else if (|(d & HOME_MASK))       return INS_HOME;
    else if (|(d & CLEAR_MASK))      return INS_CLEAR;
    else                             return INS_NOP;
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// Writer-to-panel LCD bus: enable strobe, register select, read/write and data.
interface lcd_bus_responder_if;
  import lcd_bus_responder_pkg::*;

  logic              lcd_e;
  logic              lcd_rs;
  logic              lcd_rw;
  logic [DATA_W-1:0] lcd_data;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_data);
endinterface

// File: rtl/lcd_bus_responder_addr_step.sv
// Next DDRAM address after a data write, with the line-wrap behaviour of a 2-line panel.
module lcd_bus_responder_addr_step
  import lcd_bus_responder_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] next_addr
);

  // Step up or down, jumping between the ends of line 1 and line 2
  always_comb begin
    next_addr = addr;
    if (inc) begin
      if (addr == LINE1_END)      next_addr = LINE2_BASE;
      else if (addr == LINE2_END) next_addr = LINE1_BASE;
      else                        next_addr = addr + ADDR_W'(1);
    end else begin
      if (addr == LINE1_BASE)      next_addr = LINE2_END;
      else if (addr == LINE2_BASE) next_addr = LINE1_END;
      else                         next_addr = addr - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// LCD-side model of an HD44780-style bus: decodes writes on the falling edge of
// lcd_e, keeps a 2x16 DDRAM image, address counter and busy timing, and flags misuse.
module lcd_bus_responder
  import lcd_bus_responder_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_bus_responder_if.slave   bus,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DATA_W-1:0]    rd_char,
  output logic [ADDR_W-1:0]    cursor_addr,
  output logic                 disp_on,
  output logic                 busy,
  output logic                 wr_pulse,
  output logic                 cmd_pulse,
  output logic                 overrun,
  output logic                 rw_err
);

  localparam int unsigned MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

  logic [DATA_W-1:0] ddram [2*LINE_LEN];
  logic              e_q;
  logic              id_q;
  logic              s_q;
  logic [CNT_W-1:0]  busy_cnt;

  logic              ev;
  logic              accept;
  instr_e            instr;
  logic              long_busy;
  logic              do_clear;
  logic              store_hit;
  logic [IDX_W-1:0]  store_idx;
  logic              do_store;
  logic [ADDR_W-1:0] step_addr;

  // Entry-mode shift bit is held for completeness but has no effect on the model
  logic unused_entry_shift;
  assign unused_entry_shift = s_q;

  lcd_bus_responder_addr_step u_addr_step (
    .addr      (cursor_addr),
    .inc       (id_q),
    .next_addr (step_addr)
  );

  assign busy    = (busy_cnt != '0);
  assign rd_char = ddram[rd_idx];

  // Transfer detection, instruction class and DDRAM slot of the current address
  always_comb begin
    ev        = e_q & ~bus.lcd_e;
    accept    = ev & ~bus.lcd_rw;
    instr     = decode_instr(bus.lcd_data);
    long_busy = ~bus.lcd_rs && (instr == INS_CLEAR || instr == INS_HOME);
    do_clear  = accept && ~bus.lcd_rs && (instr == INS_CLEAR);
    // Line 1 occupies 0x00-0x0F, line 2 occupies 0x40-0x4F
    store_hit = (cursor_addr[6:4] == 3'b000) || (cursor_addr[6:4] == 3'b100);
    store_idx = {cursor_addr[6], cursor_addr[3:0]};
    do_store  = accept & bus.lcd_rs & store_hit;
  end

  // Control state: strobe history, address counter, mode bits, busy timer and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q         <= 1'b0;
      cursor_addr <= LINE1_BASE;
      id_q        <= 1'b1;
      s_q         <= 1'b0;
      disp_on     <= 1'b0;
      busy_cnt    <= '0;
      wr_pulse    <= 1'b0;
      cmd_pulse   <= 1'b0;
      overrun     <= 1'b0;
      rw_err      <= 1'b0;
    end else begin
      e_q       <= bus.lcd_e;
      wr_pulse  <= 1'b0;
      cmd_pulse <= 1'b0;
      if (busy) busy_cnt <= busy_cnt - CNT_W'(1);
      if (ev && bus.lcd_rw) rw_err <= 1'b1;
      if (accept) begin
        // A transfer during busy is still executed; it only gets flagged
        if (busy) overrun <= 1'b1;
        busy_cnt <= long_busy ? CLEAR_LOAD : BUSY_LOAD;
        if (bus.lcd_rs) begin
          wr_pulse    <= 1'b1;
          cursor_addr <= step_addr;
        end else begin
          cmd_pulse <= 1'b1;
          unique case (instr)
            INS_SET_DDRAM:  cursor_addr <= bus.lcd_data[ADDR_W-1:0];
            INS_DISP_CTRL:  disp_on     <= bus.lcd_data[DISP_D_BIT];
            INS_ENTRY_MODE: begin
              id_q <= bus.lcd_data[ENTRY_ID_BIT];
              s_q  <= bus.lcd_data[ENTRY_S_BIT];
            end
            INS_HOME:       cursor_addr <= LINE1_BASE;
            INS_CLEAR: begin
              cursor_addr <= LINE1_BASE;
              id_q        <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // DDRAM image: filled with spaces on reset and clear, written by data transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2*LINE_LEN; i++) ddram[i] <= SPACE_CHAR;
    end else if (do_clear) begin
      for (int i = 0; i < 2*LINE_LEN; i++) ddram[i] <= SPACE_CHAR;
    end else if (do_store) begin
      ddram[store_idx] <= bus.lcd_data;
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with short busy times (4 / 8 cycles).
module tb_lcd_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_idx;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       disp_on, busy, wr_pulse, cmd_pulse, overrun, rw_err;

  int vectors     = 0;
  int miscompares = 0;
  int wr_cnt      = 0;
  int cmd_cnt     = 0;
  logic [7:0] exp_ram [32];

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(.BUSY_CYCLES(4), .CLEAR_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rd_idx      (rd_idx),
    .rd_char     (rd_char),
    .cursor_addr (cursor_addr),
    .disp_on     (disp_on),
    .busy        (busy),
    .wr_pulse    (wr_pulse),
    .cmd_pulse   (cmd_pulse),
    .overrun     (overrun),
    .rw_err      (rw_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse === 1'b1)  wr_cnt++;
    if (cmd_pulse === 1'b1) cmd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full enable pulse; returns #1 after the edge that commits the transfer
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(posedge clk); #1;
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d; bus.lcd_e = 1'b1;
    @(posedge clk); #1;
    bus.lcd_e = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_char(input int idx, output logic [7:0] v);
    @(negedge clk);
    rd_idx = 5'(idx);
    #1;
    v = rd_char;
  endtask

  task automatic test_reset;
    logic [7:0] c;
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h00;
    rd_idx = 5'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    for (int i = 0; i < 32; i++) exp_ram[i] = 8'h20;
    for (int i = 0; i < 32; i++) begin
      read_char(i, c);
      vectors++;
      if (c !== exp_ram[i]) begin
        miscompares++;
        $display("FAIL reset_char[%0d]: got %h expected %h", i, c, exp_ram[i]);
      end
    end
    vectors++;
    if ({cursor_addr, busy, disp_on, wr_pulse, cmd_pulse, overrun, rw_err} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_state: got cursor=%h busy=%b disp=%b wr=%b cmd=%b ovr=%b rwe=%b expected all zero",
               cursor_addr, busy, disp_on, wr_pulse, cmd_pulse, overrun, rw_err);
    end
  endtask

  task automatic test_display_on;
    int c0;
    c0 = cmd_cnt;
    strobe(1'b0, 1'b0, 8'h0C);
    vectors++;
    if (cmd_pulse !== 1'b1 || wr_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL disp_pulses: got cmd=%b wr=%b expected cmd=1 wr=0", cmd_pulse, wr_pulse);
    end
    vectors++;
    if (disp_on !== 1'b1) begin
      miscompares++;
      $display("FAIL disp_on: got %b expected 1", disp_on);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (busy !== (i < 4)) begin
        miscompares++;
        $display("FAIL disp_busy[%0d]: got %b expected %b", i, busy, (i < 4));
      end
      idle(1);
    end
    vectors++;
    if (cmd_cnt - c0 !== 1) begin
      miscompares++;
      $display("FAIL disp_cmd_count: got %0d expected 1", cmd_cnt - c0);
    end
  endtask

  task automatic test_data_write;
    int w0;
    logic [7:0] c;
    w0 = wr_cnt;
    strobe(1'b0, 1'b0, 8'h80); idle(6);
    strobe(1'b1, 1'b0, 8'h41);
    vectors++;
    if (wr_pulse !== 1'b1 || cmd_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL data_pulses: got wr=%b cmd=%b expected wr=1 cmd=0", wr_pulse, cmd_pulse);
    end
    idle(6);
    strobe(1'b1, 1'b0, 8'h42); idle(6);
    exp_ram[0] = 8'h41; exp_ram[1] = 8'h42;
    for (int i = 0; i < 2; i++) begin
      read_char(i, c);
      vectors++;
      if (c !== exp_ram[i]) begin
        miscompares++;
        $display("FAIL data_char[%0d]: got %h expected %h", i, c, exp_ram[i]);
      end
    end
    vectors++;
    if (cursor_addr !== 7'h02) begin
      miscompares++;
      $display("FAIL data_cursor: got %h expected 02", cursor_addr);
    end
    vectors++;
    if (wr_cnt - w0 !== 2) begin
      miscompares++;
      $display("FAIL data_wr_count: got %0d expected 2", wr_cnt - w0);
    end
  endtask

  task automatic test_line2_end;
    logic [7:0] c;
    strobe(1'b0, 1'b0, 8'hCF); idle(6);
    strobe(1'b1, 1'b0, 8'h5A); idle(6);
    exp_ram[31] = 8'h5A;
    read_char(31, c);
    vectors++;
    if (c !== 8'h5A) begin
      miscompares++;
      $display("FAIL line2_char31: got %h expected 5a", c);
    end
    vectors++;
    if (cursor_addr !== 7'h50) begin
      miscompares++;
      $display("FAIL line2_cursor: got %h expected 50", cursor_addr);
    end
    strobe(1'b1, 1'b0, 8'h5B); idle(6);
    vectors++;
    if (cursor_addr !== 7'h51) begin
      miscompares++;
      $display("FAIL offmap_cursor: got %h expected 51", cursor_addr);
    end
    for (int i = 0; i < 32; i++) begin
      read_char(i, c);
      vectors++;
      if (c !== exp_ram[i]) begin
        miscompares++;
        $display("FAIL offmap_char[%0d]: got %h expected %h", i, c, exp_ram[i]);
      end
    end
  endtask

  task automatic test_line1_wrap;
    logic [7:0] c;
    strobe(1'b0, 1'b0, 8'hA7); idle(6);
    strobe(1'b1, 1'b0, 8'h31); idle(6);
    vectors++;
    if (cursor_addr !== 7'h40) begin
      miscompares++;
      $display("FAIL wrap_cursor: got %h expected 40", cursor_addr);
    end
    for (int i = 0; i < 32; i++) begin
      read_char(i, c);
      vectors++;
      if (c !== exp_ram[i]) begin
        miscompares++;
        $display("FAIL wrap_char[%0d]: got %h expected %h", i, c, exp_ram[i]);
      end
    end
  endtask

  task automatic test_decrement;
    logic [7:0] c;
    strobe(1'b0, 1'b0, 8'h04); idle(6);
    strobe(1'b0, 1'b0, 8'h80); idle(6);
    strobe(1'b1, 1'b0, 8'h33); idle(6);
    exp_ram[0] = 8'h33;
    read_char(0, c);
    vectors++;
    if (c !== 8'h33) begin
      miscompares++;
      $display("FAIL dec_char0: got %h expected 33", c);
    end
    vectors++;
    if (cursor_addr !== 7'h67) begin
      miscompares++;
      $display("FAIL dec_cursor: got %h expected 67", cursor_addr);
    end
  endtask

  task automatic test_clear;
    logic [7:0] c;
    strobe(1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (busy !== (i < 8)) begin
        miscompares++;
        $display("FAIL clear_busy[%0d]: got %b expected %b", i, busy, (i < 8));
      end
      idle(1);
    end
    for (int i = 0; i < 32; i++) exp_ram[i] = 8'h20;
    for (int i = 0; i < 32; i++) begin
      read_char(i, c);
      vectors++;
      if (c !== exp_ram[i]) begin
        miscompares++;
        $display("FAIL clear_char[%0d]: got %h expected %h", i, c, exp_ram[i]);
      end
    end
    vectors++;
    if (cursor_addr !== 7'h00) begin
      miscompares++;
      $display("FAIL clear_cursor: got %h expected 00", cursor_addr);
    end
    // Clear restores increment mode
    strobe(1'b1, 1'b0, 8'h44); idle(6);
    exp_ram[0] = 8'h44;
    read_char(0, c);
    vectors++;
    if (c !== 8'h44 || cursor_addr !== 7'h01) begin
      miscompares++;
      $display("FAIL clear_incmode: got char=%h cursor=%h expected char=44 cursor=01", c, cursor_addr);
    end
  endtask

  task automatic test_overrun;
    strobe(1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 32; i++) exp_ram[i] = 8'h20;
    vectors++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_before: got overrun=%b busy=%b expected overrun=0 busy=1", overrun, busy);
    end
    idle(1);
    strobe(1'b0, 1'b0, 8'h02);
    vectors++;
    if (overrun !== 1'b1 || cmd_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set: got overrun=%b cmd=%b expected overrun=1 cmd=1", overrun, cmd_pulse);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (busy !== (i < 8)) begin
        miscompares++;
        $display("FAIL ovr_restart_busy[%0d]: got %b expected %b", i, busy, (i < 8));
      end
      idle(1);
    end
  endtask

  task automatic test_rw_err;
    logic [7:0] c;
    int w0;
    w0 = wr_cnt;
    strobe(1'b1, 1'b1, 8'h55);
    vectors++;
    if (rw_err !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_err_set: got %b expected 1", rw_err);
    end
    vectors++;
    if (wr_pulse !== 1'b0 || cmd_pulse !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_side_effects: got wr=%b cmd=%b busy=%b expected 0 0 0", wr_pulse, cmd_pulse, busy);
    end
    idle(3);
    read_char(0, c);
    vectors++;
    if (c !== exp_ram[0] || cursor_addr !== 7'h00 || wr_cnt != w0) begin
      miscompares++;
      $display("FAIL rw_no_store: got char=%h cursor=%h wr_delta=%0d expected char=%h cursor=00 wr_delta=0",
               c, cursor_addr, wr_cnt - w0, exp_ram[0]);
    end
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
    bus.lcd_rw = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    strobe(1'b0, 1'b0, 8'h0C);
    idle(1);
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, disp_on, overrun, rw_err, cursor_addr} !== 11'h0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b disp=%b ovr=%b rwe=%b cursor=%h expected all zero",
               busy, disp_on, overrun, rw_err, cursor_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort_busy: got %b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_display_on();
    test_data_write();
    test_line2_end();
    test_line1_wrap();
    test_decrement();
    test_clear();
    test_overrun();
    test_rw_err();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
